// File: rtl/base_and_or_arb.sv
`default_nettype none
// ============================================================================
// Module   : base_and_or_arb
// Brief    : Round-robin arbiter that shares one combinational AND/OR unit
//            between two valid/ready requesters and returns the registered
//            result on a single ID-tagged response channel.
// Revision : 1.0 - initial release
// ============================================================================
module base_and_or_arb #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstN,
   // requester 0
   input  logic             req0Valid,
   output logic             req0Ready,
   input  logic             req0IsAnd,
   input  logic [WIDTH-1:0] req0A,
   input  logic [WIDTH-1:0] req0B,
   // requester 1
   input  logic             req1Valid,
   output logic             req1Ready,
   input  logic             req1IsAnd,
   input  logic [WIDTH-1:0] req1A,
   input  logic [WIDTH-1:0] req1B,
   // response channel
   output logic             respValid,
   input  logic             respReady,
   output logic             respId,
   output logic [WIDTH-1:0] respData,
   // shared logic unit
   output logic [WIDTH-1:0] luA,
   output logic [WIDTH-1:0] luB,
   output logic             luDoAnd,
   output logic             luDoOr,
   input  logic [WIDTH-1:0] luOut,
   input  logic             luIsAnd,
   // status
   output logic             opErr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_rr_ptr;
   logic [WIDTH-1:0] r_cap_a;
   logic [WIDTH-1:0] r_cap_b;
   logic             r_cap_op;
   logic             r_cap_id;
   logic             r_resp_valid;
   logic             r_resp_id;
   logic [WIDTH-1:0] r_resp_data;
   logic             r_op_err;

   logic             w_idle;
   logic             w_issue;
   logic             w_grant0;
   logic             w_grant1;
   logic             w_accept;
   logic             w_resp_hs;

   assign w_idle  = (r_state == ST_IDLE);
   assign w_issue = (r_state == ST_ISSUE);

   // A lone valid requester always wins; on contention rrPtr picks the winner.
   assign w_grant0  = req0Valid & (~req1Valid | ~r_rr_ptr);
   assign w_grant1  = req1Valid & (~req0Valid |  r_rr_ptr);
   assign w_accept  = w_idle & (w_grant0 | w_grant1);
   assign w_resp_hs = r_resp_valid & respReady;

   // Ready only in IDLE, so nothing is accepted while an operation is in flight.
   assign req0Ready = w_idle & w_grant0;
   assign req1Ready = w_idle & w_grant1;

   // Operands stay parked on the unit; only the selects pulse during ISSUE.
   assign luA     = r_cap_a;
   assign luB     = r_cap_b;
   assign luDoAnd = w_issue &  r_cap_op;
   assign luDoOr  = w_issue & ~r_cap_op;

   assign respValid = r_resp_valid;
   assign respId    = r_resp_id;
   assign respData  = r_resp_data;
   assign opErr     = r_op_err;

   // State register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: IDLE -> ISSUE on accept, ISSUE -> RESP always,
   // RESP -> IDLE on response handshake.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (w_resp_hs) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Capture the granted request's operands, opcode and ID on acceptance.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_cap_a  <= '0;
         r_cap_b  <= '0;
         r_cap_op <= 1'b0;
         r_cap_id <= 1'b0;
      end else if (w_accept) begin
         r_cap_a  <= w_grant1 ? req1A     : req0A;
         r_cap_b  <= w_grant1 ? req1B     : req0B;
         r_cap_op <= w_grant1 ? req1IsAnd : req0IsAnd;
         r_cap_id <= w_grant1;
      end
   end

   // Register the unit result at the end of ISSUE and hold it until consumed;
   // the round-robin pointer moves past whoever was just served.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_resp_valid <= 1'b0;
         r_resp_id    <= 1'b0;
         r_resp_data  <= '0;
         r_rr_ptr     <= 1'b0;
      end else if (w_issue) begin
         r_resp_valid <= 1'b1;
         r_resp_id    <= r_cap_id;
         r_resp_data  <= luOut;
         r_rr_ptr     <= ~r_cap_id;
      end else if (w_resp_hs) begin
         r_resp_valid <= 1'b0;
      end
   end

   // Sticky mode-flag check; luIsAnd is only meaningful while ISSUE is active.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_op_err <= 1'b0;
      end else if (w_issue && (luIsAnd != r_cap_op)) begin
         r_op_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire
